// File: rtl/fpr_cdb_arbiter_if.sv
// FPR common-data-bus request/broadcast bundle shared by the FP execution units
// (master side) and the CDB arbiter (slave side).
interface fpr_cdb_arbiter_if #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ROB_WIDTH = 4
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*ROB_WIDTH-1:0] req_tag;
    logic [N_REQ*32-1:0]        req_data;
    // {valid, tag[ROB_WIDTH-1:0], data[31:0]}
    logic [ROB_WIDTH+32:0]      fpr_cdb;
    logic                       grant_valid;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, fpr_cdb, grant_valid
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, fpr_cdb, grant_valid
    );
endinterface

// File: rtl/fpr_cdb_arbiter.sv
// Round-robin grant of one FP result producer per cycle; the granted unit's tag
// is captured at the grant edge and its registered result broadcast one cycle later.
module fpr_cdb_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    fpr_cdb_arbiter_if.slave   bus
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]     r_rr_ptr;
    logic                 r_pend_valid;
    logic [PTR_W-1:0]     r_pend_idx;
    logic [ROB_WIDTH-1:0] r_pend_tag;

    int unsigned          w_scan;
    logic [PTR_W-1:0]     w_scan_idx;
    logic                 w_grant_any;
    logic [PTR_W-1:0]     w_grant_idx;
    logic [N_REQ-1:0]     w_grant_vec;
    logic [ROB_WIDTH-1:0] w_grant_tag;
    logic [31:0]          w_bcast_data;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_scan      = 0;
        w_scan_idx  = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_scan     = (32'(r_rr_ptr) + k) % N_REQ;
            w_scan_idx = PTR_W'(w_scan);
            if (!w_grant_any && bus.req_valid[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    // Reset masks the grant so no unit believes it transferred while flushed.
    always_comb begin
        w_grant_vec = '0;
        if (w_grant_any && !reset) begin
            w_grant_vec[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_grant_tag  = '0;
        w_bcast_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                w_grant_tag = bus.req_tag[i*ROB_WIDTH +: ROB_WIDTH];
            end
            if (r_pend_idx == PTR_W'(i)) begin
                w_bcast_data = bus.req_data[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
            r_pend_tag   <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr     <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + PTR_W'(1);
            r_pend_valid <= 1'b1;
            r_pend_idx   <= w_grant_idx;
            r_pend_tag   <= w_grant_tag;
        end else begin
            r_pend_valid <= 1'b0;
        end
    end

    assign bus.req_ready   = w_grant_vec;
    assign bus.grant_valid = |w_grant_vec;
    assign bus.fpr_cdb     = {r_pend_valid, r_pend_tag, w_bcast_data};

    a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.req_ready));
    a_ready_needs_valid: assert property (@(posedge clk) disable iff (reset)
        (bus.req_ready & ~bus.req_valid) == '0);
    a_pend_idx_range: assert property (@(posedge clk) disable iff (reset)
        r_pend_valid |-> (32'(r_pend_idx) < N_REQ));
endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Directed bench for fpr_cdb_arbiter with N_REQ=4, ROB_WIDTH=4.
module tb_fpr_cdb_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fpr_cdb_arbiter_if #(.N_REQ(4), .ROB_WIDTH(4)) bus ();

    fpr_cdb_arbiter #(.N_REQ(4), .ROB_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic        cdb_v;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    assign cdb_v    = bus.fpr_cdb[36];
    assign cdb_tag  = bus.fpr_cdb[35:32];
    assign cdb_data = bus.fpr_cdb[31:0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tag(input int i, input logic [3:0] v);
        bus.req_tag[i*4 +: 4] = v;
    endtask

    task automatic set_data(input int i, input logic [31:0] v);
        bus.req_data[i*32 +: 32] = v;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_tag   = '0;
        bus.req_data  = '0;

        // Reset state: ready forced low even with all units requesting
        #2;
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_gv", 64'(bus.grant_valid), 64'h0);
        check("rst_cdb_v", 64'(cdb_v), 64'h0);
        check("rst_ptr", 64'(dut.r_rr_ptr), 64'h0);
        tick();
        tick();
        reset         = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        check("idle_ready", 64'(bus.req_ready), 64'h0);

        // 1: single request from unit 1
        tick();
        bus.req_valid = 4'b0010;
        set_tag(1, 4'd5);
        #1;
        check("t1_ready", 64'(bus.req_ready), 64'h2);
        check("t1_gv", 64'(bus.grant_valid), 64'h1);
        tick();
        bus.req_valid = 4'b0000;
        set_tag(1, 4'd0);
        set_data(1, 32'h3F80_0000);
        #1;
        check("t1_cdb", 64'(bus.fpr_cdb), {27'h0, 1'b1, 4'd5, 32'h3F80_0000});
        check("t1_ptr", 64'(dut.r_rr_ptr), 64'h2);
        check("t1_ready_after", 64'(bus.req_ready), 64'h0);

        // 4: idle after a grant, broadcast lasts a single cycle
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check("t4_cdb_v", 64'(cdb_v), 64'h0);
            check("t4_ready", 64'(bus.req_ready), 64'h0);
        end
        check("t4_ptr_hold", 64'(dut.r_rr_ptr), 64'h2);

        // 3: wrap-around; first move rr_ptr to 3 by granting unit 2
        for (int i = 0; i < 4; i++) begin
            set_tag(i, 4'(8 + i));
            set_data(i, 32'hD000_0000 + 32'(i));
        end
        bus.req_valid = 4'b0100;
        #1;
        check("t3_pre_ready", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = 4'b1001;
        #1;
        check("t3_ptr3", 64'(dut.r_rr_ptr), 64'h3);
        check("t3_ready_3", 64'(bus.req_ready), 64'h8);
        check("t3_cdb_tag2", 64'(cdb_tag), 64'hA);
        tick();
        #1;
        check("t3_ptr0", 64'(dut.r_rr_ptr), 64'h0);
        check("t3_ready_0", 64'(bus.req_ready), 64'h1);
        check("t3_cdb_v", 64'(cdb_v), 64'h1);
        check("t3_cdb_tag3", 64'(cdb_tag), 64'hB);
        check("t3_cdb_data3", 64'(cdb_data), 64'hD000_0003);
        tick();
        bus.req_valid = 4'b0000;
        #1;
        check("t3_cdb_tag0", 64'(cdb_tag), 64'h8);
        check("t3_cdb_data0", 64'(cdb_data), 64'hD000_0000);
        check("t3_ptr1", 64'(dut.r_rr_ptr), 64'h1);
        tick();

        // 2: all four requesting continuously from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_tag(i, 4'(4 + i));
            set_data(i, 32'hA000_0000 | 32'(i));
        end
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t2_ready", 64'(bus.req_ready), 64'(1 << (c % 4)));
            check("t2_cdb_v", 64'(cdb_v), (c > 0) ? 64'h1 : 64'h0);
            if (c > 0) begin
                check("t2_cdb_tag", 64'(cdb_tag), 64'(((c - 1) % 4) + 4));
                check("t2_cdb_data", 64'(cdb_data), 64'hA000_0000 | 64'((c - 1) % 4));
            end
            tick();
        end
        bus.req_valid = 4'b0000;
        #1;
        check("t2_last_v", 64'(cdb_v), 64'h1);
        check("t2_last_tag", 64'(cdb_tag), 64'h7);
        check("t2_last_ready", 64'(bus.req_ready), 64'h0);
        tick();
        #1;
        check("t2_drain_v", 64'(cdb_v), 64'h0);

        // 6: back-to-back grants to unit 1 with tags 1,2,3
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = (k < 3) ? 4'b0010 : 4'b0000;
            set_tag(1, 4'(k + 1));
            set_data(1, (k > 0) ? (32'h4040_0000 + 32'(k)) : 32'h0);
            #1;
            check("t6_ready", 64'(bus.req_ready), (k < 3) ? 64'h2 : 64'h0);
            if (k > 0) begin
                check("t6_cdb_v", 64'(cdb_v), 64'h1);
                check("t6_cdb_tag", 64'(cdb_tag), 64'(k));
                check("t6_cdb_data", 64'(cdb_data), 64'h4040_0000 + 64'(k));
            end
            tick();
        end
        #1;
        check("t6_drain_v", 64'(cdb_v), 64'h0);
        check("t6_ptr", 64'(dut.r_rr_ptr), 64'h2);

        // 5: reset asserted in the grant cycle of unit 2
        bus.req_valid = 4'b0100;
        set_tag(2, 4'd9);
        #1;
        check("t5_ready", 64'(bus.req_ready), 64'h4);
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_ready", 64'(bus.req_ready), 64'h0);
        check("t5_rst_gv", 64'(bus.grant_valid), 64'h0);
        check("t5_rst_ptr", 64'(dut.r_rr_ptr), 64'h0);
        tick();
        check("t5_rst_cdb_v", 64'(cdb_v), 64'h0);
        reset         = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        check("t5_post_cdb_v", 64'(cdb_v), 64'h0);
        check("t5_post_ptr", 64'(dut.r_rr_ptr), 64'h0);
        bus.req_valid = 4'b1111;
        #1;
        check("t5_post_ready", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fpr_cdb_arbiter.md
Name: fpr_cdb_arbiter

Overview:
- Responder end of the FPR common-data-bus request handshake.
- Every FPR-producing unit (fmov, fadd, fmul, finv, ...) raises a request with its ROB tag. This block grants one requester per cycle, round-robin.
- One cycle after the grant, it broadcasts {valid, tag, data} on the FPR CDB. The data is the granted unit's registered result.
- Sits between the FP execution units and the FPR-side consumers: reservation stations, register file, ROB.

Parameters:
- N_REQ, 4, number of requesting units; must be ≥2.
- ROB_WIDTH, 4, ROB tag width; must equal the global ROB_WIDTH.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- req_valid  input  N_REQ  per-unit request (fpr_cdb_req.valid of unit i).
- req_ready  output  N_REQ  per-unit grant (fpr_cdb_req.ready of unit i); at most one bit high.
- req_tag  input  N_REQ×ROB_WIDTH  unit i's tag; sampled in the grant cycle.
- req_data  input  N_REQ×32  unit i's result; sampled one cycle after the grant.
- fpr_cdb  output  1+ROB_WIDTH+32  cdb_t {valid, tag, data} broadcast.
- grant_valid  output  1  a grant was issued this cycle (= |req_ready), for performance counters.

Behaviour:
- Handshake: unit i transfers when req_valid[i] && req_ready[i] in cycle t. Unit i registers its result at the end of cycle t, so req_data[i] is valid in cycle t+1 only.
- Grant logic is combinational from req_valid and rr_ptr:
  - Scan indices rr_ptr, rr_ptr+1, ..., wrapping mod N_REQ.
  - Grant the first index with req_valid set.
  - No valid request: req_ready = 0 and grant_valid = 0.
  - req_ready never depends on req_tag or req_data.
- State: rr_ptr (log2 N_REQ, min 1 bit), pend_valid, pend_idx, pend_tag.
- Posedge, grant to index g:
  - rr_ptr <= (g+1) mod N_REQ; wrap from N_REQ-1 to 0.
  - pend_valid <= 1, pend_idx <= g, pend_tag <= req_tag[g].
- Posedge, no grant: pend_valid <= 0. rr_ptr holds, pend_idx and pend_tag hold.
- Broadcast, combinational from pend registers:
  - fpr_cdb.valid = pend_valid.
  - fpr_cdb.tag = pend_tag.
  - fpr_cdb.data = req_data[pend_idx].
  - When pend_valid = 0, tag and data are don't-care; bench checks them only when valid.
- Latency and throughput: grant in cycle t → CDB valid in cycle t+1, exactly one cycle. Sustained throughput is one broadcast per cycle; back-to-back grants to the same unit are allowed.
- Fairness: with all N_REQ requesting continuously, each unit is granted exactly once every N_REQ cycles.
- A request withdrawn before grant is legal. No grant results and no broadcast results.
- Simultaneous grant and broadcast in the same cycle are independent: the new grant overwrites the pend registers at the edge.
- Reset (async, active-high):
  - Values while asserted: pend_valid = 0, rr_ptr = 0, pend_idx = 0, pend_tag = 0, fpr_cdb.valid = 0, req_ready all 0, grant_valid = 0.
  - req_ready is forced low during reset regardless of req_valid.
  - Reset mid-operation drops any pending broadcast. A unit granted in the cycle reset asserts is not broadcast; the flush discards its ROB entry.
- Assertions:
  - $onehot0(req_ready).
  - No req_ready[i] without req_valid[i].
  - fpr_cdb.valid implies pend_idx < N_REQ.

Test Plan:
1. Single request, N_REQ=4, rr_ptr=0; req_valid=0010, req_tag[1]=5; next cycle req_data[1]=0x3F800000 → req_ready=0010 in cycle t. In cycle t+1, fpr_cdb={1, 5, 0x3F800000} and rr_ptr=2.
2. All four requesting continuously for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3. fpr_cdb.valid=1 in cycles 1–8; each broadcast tag matches its granted unit's tag.
3. Wrap-around: rr_ptr=3, req_valid=1001 → grant 3 (req_ready=1000), then rr_ptr=0. Next cycle the same requests → grant 0.
4. Idle: req_valid=0000 for 3 cycles after a grant → fpr_cdb.valid=1 for one cycle only, then 0. req_ready=0 throughout.
5. Reset mid-operation: grant unit 2 in cycle t, assert reset before the t+1 edge → fpr_cdb.valid=0 immediately, req_ready=0000, rr_ptr=0 after release.
6. Back-to-back same unit: only unit 1 requests for 3 cycles with tags 1, 2, 3 → three consecutive broadcasts with tags 1, 2, 3 and matching data.
